// File: rtl/tdm_pkg.sv
// Shared definitions for the 4-lane 1-bit TDM link (transmit and receive sides).
package tdm_pkg;

  localparam int NUM_LANES = 4;
  localparam int SEL_W     = 2;

  typedef logic [SEL_W-1:0] slot_t;

  typedef enum logic {
    HUNT,
    COLLECT
  } state_t;

  // A 1-bit lane word still needs a 1-bit counter to keep port widths legal.
  function automatic int bcnt_width(input int width);
    return (width > 1) ? $clog2(width) : 1;
  endfunction

endpackage

// File: rtl/tdm_lane_shift.sv
// One lane word register: writes a single bit at a given index, optionally
// clearing the word in the same cycle.
module tdm_lane_shift #(
  parameter int WIDTH = 8,
  parameter int IDX_W = 3
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear_i,
  input  logic             we_i,
  input  logic [IDX_W-1:0] idx_i,
  input  logic             bit_i,
  output logic [WIDTH-1:0] word_next_o
);

  logic [WIDTH-1:0] word_q;
  logic [WIDTH-1:0] word_d;

  // The next value is exported so the top can capture a frame including the bit landing this cycle.
  always_comb begin
    word_d = clear_i ? '0 : word_q;
    if (we_i) begin
      word_d[idx_i] = bit_i;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      word_q <= '0;
    end else begin
      word_q <= word_d;
    end
  end

  assign word_next_o = word_d;

endmodule

// File: rtl/tdm_demux.sv
// TDM receiver: tracks slot rotation from in_sof, steers bits into four lane
// words and presents each completed frame on a valid/ready output.
module tdm_demux
  import tdm_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic                       in_bit,
  input  logic                       in_sof,
  output logic                       out_valid,
  input  logic                       out_ready,
  output logic [NUM_LANES*WIDTH-1:0] out_data,
  output slot_t                      slot,
  output logic                       sync_err,
  output logic                       overflow
);

  localparam int                 BCNT_W   = bcnt_width(WIDTH);
  localparam logic [BCNT_W-1:0]  LAST_BIT = BCNT_W'(WIDTH - 1);
  localparam slot_t              LAST_SLOT = slot_t'(NUM_LANES - 1);

  state_t                     state_q, state_d;
  slot_t                      slot_q, slot_d;
  logic [BCNT_W-1:0]          bcnt_q, bcnt_d;
  logic                       out_valid_q, out_valid_d;
  logic [NUM_LANES*WIDTH-1:0] out_data_q, out_data_d;
  logic                       sync_err_q, sync_err_d;
  logic                       overflow_q, overflow_d;

  logic                       accept;
  slot_t                      cur_slot;
  logic [BCNT_W-1:0]          cur_bcnt;
  logic                       frame_done;
  logic                       misalign;
  logic [NUM_LANES*WIDTH-1:0] frame_next;

  // An accepted in_sof re-anchors the current bit to slot 0, bit 0.
  assign accept     = in_valid && ((state_q == COLLECT) || in_sof);
  assign cur_slot   = in_sof ? '0 : slot_q;
  assign cur_bcnt   = in_sof ? '0 : bcnt_q;
  assign frame_done = accept && (cur_slot == LAST_SLOT) && (cur_bcnt == LAST_BIT);
  assign misalign   = accept && in_sof && (state_q == COLLECT) &&
                      ((slot_q != '0) || (bcnt_q != '0));

  for (genvar n = 0; n < NUM_LANES; n++) begin : g_lane
    tdm_lane_shift #(
      .WIDTH (WIDTH),
      .IDX_W (BCNT_W)
    ) u_lane (
      .clk         (clk),
      .rst_n       (rst_n),
      .clear_i     (accept && in_sof),
      .we_i        (accept && (cur_slot == slot_t'(n))),
      .idx_i       (cur_bcnt),
      .bit_i       (in_bit),
      .word_next_o (frame_next[n*WIDTH +: WIDTH])
    );
  end

  always_comb begin
    state_d     = state_q;
    slot_d      = slot_q;
    bcnt_d      = bcnt_q;
    out_valid_d = out_valid_q;
    out_data_d  = out_data_q;
    sync_err_d  = 1'b0;
    overflow_d  = overflow_q;

    if (accept) begin
      if (in_sof) begin
        state_d = COLLECT;
      end
      sync_err_d = misalign;
      if (cur_slot == LAST_SLOT) begin
        slot_d = '0;
        bcnt_d = (cur_bcnt == LAST_BIT) ? '0 : cur_bcnt + 1'b1;
      end else begin
        slot_d = cur_slot + 1'b1;
        bcnt_d = cur_bcnt;
      end
    end

    if (out_valid_q && out_ready) begin
      out_valid_d = 1'b0;
    end

    // A completing frame only displaces the held one if it is leaving this cycle.
    if (frame_done) begin
      if (!out_valid_q || out_ready) begin
        out_valid_d = 1'b1;
        out_data_d  = frame_next;
      end else begin
        overflow_d = 1'b1;
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= HUNT;
      slot_q      <= '0;
      bcnt_q      <= '0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
      sync_err_q  <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      state_q     <= state_d;
      slot_q      <= slot_d;
      bcnt_q      <= bcnt_d;
      out_valid_q <= out_valid_d;
      out_data_q  <= out_data_d;
      sync_err_q  <= sync_err_d;
      overflow_q  <= overflow_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_data  = out_data_q;
  assign slot      = slot_q;
  assign sync_err  = sync_err_q;
  assign overflow  = overflow_q;

endmodule

// File: tb/tb_tdm_demux.sv
// Self-checking bench for tdm_demux: WIDTH=8 scenarios plus a WIDTH=1 instance.
module tb_tdm_demux;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic        in_valid = 1'b0;
  logic        in_bit = 1'b0;
  logic        in_sof = 1'b0;
  logic        out_ready = 1'b0;
  logic        out_valid;
  logic [31:0] out_data;
  logic [1:0]  slot;
  logic        sync_err;
  logic        overflow;

  logic        w1_in_valid = 1'b0;
  logic        w1_in_bit = 1'b0;
  logic        w1_in_sof = 1'b0;
  logic        w1_out_ready = 1'b1;
  logic        w1_out_valid;
  logic [3:0]  w1_out_data;
  logic [1:0]  w1_slot;
  logic        w1_sync_err;
  logic        w1_overflow;

  int          vectors = 0;
  int          miscompares = 0;
  logic [31:0] sb[$];
  logic [3:0]  w1_sb[$];

  always #5 clk = ~clk;

  tdm_demux #(.WIDTH(8)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_bit    (in_bit),
    .in_sof    (in_sof),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .out_data  (out_data),
    .slot      (slot),
    .sync_err  (sync_err),
    .overflow  (overflow)
  );

  tdm_demux #(.WIDTH(1)) dut_w1 (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (w1_in_valid),
    .in_bit    (w1_in_bit),
    .in_sof    (w1_in_sof),
    .out_valid (w1_out_valid),
    .out_ready (w1_out_ready),
    .out_data  (w1_out_data),
    .slot      (w1_slot),
    .sync_err  (w1_sync_err),
    .overflow  (w1_overflow)
  );

  task automatic do_reset();
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0; in_sof = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    sb.delete();
  endtask

  task automatic idle();
    @(negedge clk);
    in_valid = 1'b0; in_sof = 1'b0; in_bit = 1'b0; out_ready = 1'b0;
  endtask

  task automatic drive_bit(input logic b, input logic sof);
    @(negedge clk);
    in_valid = 1'b1; in_bit = b; in_sof = sof;
  endtask

  // Serialises lanes LSB first, interleaved slot 0..3 per bit position.
  task automatic send_frame(input logic [7:0] w0, input logic [7:0] w1,
                            input logic [7:0] w2, input logic [7:0] w3,
                            input logic sof, input logic push,
                            input logic rdy_last, input logic exp_sync);
    logic [31:0] frame;
    logic [31:0] e;
    logic        exp_bit;
    logic        last;
    int          k;
    frame = {w3, w2, w1, w0};
    k = 0;
    for (int b = 0; b < 8; b++) begin
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        if (k == 1 || k == 2) begin
          exp_bit = exp_sync && (k == 1);
          vectors++;
          if (sync_err !== exp_bit) begin
            miscompares++;
            $display("[TB] FAIL sync_err_bit%0d: got %b expected %b", k, sync_err, exp_bit);
          end
        end
        last = (b == 7) && (s == 3);
        if (last && rdy_last) begin
          vectors++;
          if (out_valid !== 1'b1 || sb.size() == 0) begin
            miscompares++;
            $display("[TB] FAIL accept_on_complete: out_valid got %b expected 1", out_valid);
          end else begin
            e = sb.pop_front();
            if (out_data !== e) begin
              miscompares++;
              $display("[TB] FAIL accept_on_complete: out_data got %h expected %h", out_data, e);
            end
          end
        end
        if (rdy_last) out_ready = last;
        in_valid = 1'b1;
        in_sof   = sof && (k == 0);
        in_bit   = frame[s*8 + b];
        k++;
      end
    end
    if (push) sb.push_back(frame);
  endtask

  task automatic receive_frame(input string name);
    logic [31:0] e;
    int n;
    n = 0;
    while (out_valid !== 1'b1 && n < 64) begin
      @(negedge clk);
      n++;
    end
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL %s_timeout: out_valid got %b expected 1", name, out_valid);
    end else if (sb.size() == 0) begin
      miscompares++;
      $display("[TB] FAIL %s: got frame %h expected none", name, out_data);
    end else begin
      e = sb.pop_front();
      if (out_data !== e) begin
        miscompares++;
        $display("[TB] FAIL %s: out_data got %h expected %h", name, out_data, e);
      end
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    vectors++;
    if (out_valid !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL %s_drain: out_valid got %b expected 0", name, out_valid);
    end
  endtask

  task automatic test_reset();
    @(negedge clk);
    vectors++;
    if ({out_valid, out_data, slot, sync_err, overflow} !== 37'd0) begin
      miscompares++;
      $display("[TB] FAIL reset_outputs: got %h expected 0", {out_valid, out_data, slot, sync_err, overflow});
    end
    rst_n = 1'b1;
    @(negedge clk);
    vectors++;
    if ({out_valid, out_data, slot, overflow} !== 36'd0) begin
      miscompares++;
      $display("[TB] FAIL post_reset: got %h expected 0", {out_valid, out_data, slot, overflow});
    end
  endtask

  task automatic test_basic();
    do_reset();
    send_frame(8'hA5, 8'h3C, 8'hFF, 8'h01, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    vectors++;
    if (out_valid !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL basic_latency: out_valid got %b expected 1", out_valid);
    end
    vectors++;
    if (slot !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL basic_slot_wrap: slot got %0d expected 0", slot);
    end
    idle();
    idle();
    receive_frame("basic_frame");
  endtask

  task automatic test_no_sof();
    do_reset();
    for (int i = 0; i < 10; i++) drive_bit(i[0], 1'b0);
    idle();
    vectors++;
    if (out_valid !== 1'b0 || slot !== 2'd0) begin
      miscompares++;
      $display("[TB] FAIL hunt_ignore: out_valid/slot got %b/%0d expected 0/0", out_valid, slot);
    end
  endtask

  task automatic test_overflow();
    do_reset();
    send_frame(8'h12, 8'h34, 8'h56, 8'h78, 1'b1, 1'b1, 1'b0, 1'b0);
    send_frame(8'hDE, 8'hAD, 8'hBE, 8'hEF, 1'b0, 1'b0, 1'b0, 1'b0);
    idle();
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_set: got %b expected 1", overflow);
    end
    vectors++;
    if (out_valid !== 1'b1 || out_data !== 32'h78563412) begin
      miscompares++;
      $display("[TB] FAIL overflow_hold: out_data got %h expected 78563412", out_data);
    end
    receive_frame("overflow_frame");
    vectors++;
    if (overflow !== 1'b1) begin
      miscompares++;
      $display("[TB] FAIL overflow_sticky: got %b expected 1", overflow);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    send_frame(8'h11, 8'h22, 8'h33, 8'h44, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    send_frame(8'hC3, 8'h5A, 8'h0F, 8'hF0, 1'b0, 1'b1, 1'b1, 1'b0);
    idle();
    vectors++;
    if (out_valid !== 1'b1 || overflow !== 1'b0) begin
      miscompares++;
      $display("[TB] FAIL simul_flags: valid/overflow got %b/%b expected 1/0", out_valid, overflow);
    end
    receive_frame("simul_frame2");
  endtask

  task automatic test_back_to_back();
    logic [31:0] r;
    do_reset();
    r = $urandom;
    send_frame(r[7:0], r[15:8], r[23:16], r[31:24], 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    receive_frame("b2b_first");
    r = $urandom;
    send_frame(r[7:0], r[15:8], r[23:16], r[31:24], 1'b0, 1'b1, 1'b0, 1'b0);
    idle();
    receive_frame("b2b_no_sof");
  endtask

  task automatic test_sync_err();
    do_reset();
    for (int i = 0; i < 14; i++) drive_bit(1'b1, i == 0);
    idle();
    vectors++;
    if (slot !== 2'd2) begin
      miscompares++;
      $display("[TB] FAIL presync_slot: got %0d expected 2", slot);
    end
    send_frame(8'h9C, 8'h00, 8'h7E, 8'h81, 1'b1, 1'b1, 1'b0, 1'b1);
    idle();
    receive_frame("resync_frame");
  endtask

  task automatic test_reset_mid();
    do_reset();
    send_frame(8'hAA, 8'h55, 8'hCC, 8'h33, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 17; i++) drive_bit(1'b1, 1'b0);
    @(negedge clk);
    rst_n = 1'b0;
    in_valid = 1'b0;
    #1;
    vectors++;
    if ({out_valid, out_data, slot, sync_err, overflow} !== 37'd0) begin
      miscompares++;
      $display("[TB] FAIL async_reset: got %h expected 0", {out_valid, out_data, slot, sync_err, overflow});
    end
    sb.delete();
    @(negedge clk);
    rst_n = 1'b1;
    send_frame(8'h0D, 8'hF0, 8'h42, 8'hB7, 1'b1, 1'b1, 1'b0, 1'b0);
    idle();
    receive_frame("after_reset");
  endtask

  task automatic test_width1();
    logic [3:0] pat;
    logic [3:0] e;
    for (int f = 0; f < 2; f++) begin
      pat = (f == 0) ? 4'b1101 : 4'b0110;
      for (int s = 0; s < 4; s++) begin
        @(negedge clk);
        w1_in_valid = 1'b1;
        w1_in_sof   = (f == 0) && (s == 0);
        w1_in_bit   = pat[s];
      end
      w1_sb.push_back(pat);
      @(negedge clk);
      w1_in_valid = 1'b0;
      w1_in_sof   = 1'b0;
      e = w1_sb.pop_front();
      vectors++;
      if (w1_out_valid !== 1'b1 || w1_out_data !== e) begin
        miscompares++;
        $display("[TB] FAIL width1_frame%0d: valid/data got %b/%b expected 1/%b", f, w1_out_valid, w1_out_data, e);
      end
    end
    vectors++;
    if ({w1_overflow, w1_sync_err, w1_slot} !== 4'd0) begin
      miscompares++;
      $display("[TB] FAIL width1_status: got %b expected 0000", {w1_overflow, w1_sync_err, w1_slot});
    end
  endtask

  initial begin
    repeat (2) @(negedge clk);
    test_reset();
    test_basic();
    test_no_sof();
    test_overflow();
    test_simultaneous();
    test_back_to_back();
    test_sync_err();
    test_reset_mid();
    test_width1();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
